// File: rtl/bmu_req_arbiter.sv
// Round-robin front end that shares one BMU between NUM_REQ requesters,
// tags each issued op and returns results in issue order through a credited FIFO.
module bmu_req_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned AP_W      = 32,
  parameter int unsigned BMU_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 4,
  localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*AP_W-1:0] req_ap,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ-1:0]      req_csr_ren,
  input  logic [NUM_REQ*32-1:0]   req_csr_rddata,
  output logic                    bmu_valid_in,
  output logic [AP_W-1:0]         bmu_ap,
  output logic [31:0]             bmu_a_in,
  output logic [31:0]             bmu_b_in,
  output logic                    bmu_csr_ren_in,
  output logic [31:0]             bmu_csr_rddata_in,
  input  logic [31:0]             bmu_result_ff,
  input  logic                    bmu_error,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_error
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic                r_run;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_issue_id;
  logic                r_bmu_valid;
  logic [AP_W-1:0]     r_bmu_ap;
  logic [31:0]         r_bmu_a;
  logic [31:0]         r_bmu_b;
  logic                r_bmu_csr_ren;
  logic [31:0]         r_bmu_csr_rddata;
  logic                r_tag_v  [BMU_LAT];
  logic [ID_W-1:0]     r_tag_id [BMU_LAT];
  logic [CNT_W-1:0]    r_inflight;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [ID_W-1:0]     r_mem_id   [RSP_DEPTH];
  logic [31:0]         r_mem_data [RSP_DEPTH];
  logic                r_mem_err  [RSP_DEPTH];

  logic                w_issue_ok;
  logic                w_gnt_v;
  logic [ID_W-1:0]     w_gnt_id;
  logic                w_hs;
  logic [NUM_REQ-1:0]  w_ready;
  logic [AP_W-1:0]     w_sel_ap;
  logic [31:0]         w_sel_a;
  logic [31:0]         w_sel_b;
  logic                w_sel_csr_ren;
  logic [31:0]         w_sel_csr_rddata;
  logic                w_cap;
  logic                w_rsp_v;
  logic                w_pop;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
  endfunction

  // Pop credit only returns the cycle after the pop, since both counts are registered.
  assign w_issue_ok = r_run && !flush &&
                      (((CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight)) < (CNT_W+1)'(RSP_DEPTH));

  // Round-robin search starting at r_rr_ptr.
  always_comb begin
    w_gnt_v  = 1'b0;
    w_gnt_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!w_gnt_v && req_valid[rr_idx(r_rr_ptr, i)]) begin
        w_gnt_v  = 1'b1;
        w_gnt_id = rr_idx(r_rr_ptr, i);
      end
    end
  end

  assign w_hs = w_issue_ok && w_gnt_v;

  always_comb begin
    w_ready = '0;
    if (w_hs) w_ready[w_gnt_id] = 1'b1;
  end

  always_comb begin
    w_sel_ap         = '0;
    w_sel_a          = '0;
    w_sel_b          = '0;
    w_sel_csr_ren    = 1'b0;
    w_sel_csr_rddata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_gnt_id) begin
        w_sel_ap         = req_ap[i*AP_W +: AP_W];
        w_sel_a          = req_a[i*32 +: 32];
        w_sel_b          = req_b[i*32 +: 32];
        w_sel_csr_ren    = req_csr_ren[i];
        w_sel_csr_rddata = req_csr_rddata[i*32 +: 32];
      end
    end
  end

  // Issue register; data holds when nothing is granted.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_run            <= 1'b0;
      r_rr_ptr         <= '0;
      r_issue_id       <= '0;
      r_bmu_valid      <= 1'b0;
      r_bmu_ap         <= '0;
      r_bmu_a          <= '0;
      r_bmu_b          <= '0;
      r_bmu_csr_ren    <= 1'b0;
      r_bmu_csr_rddata <= '0;
    end else begin
      r_run       <= 1'b1;
      r_bmu_valid <= w_hs;
      if (w_hs) begin
        r_issue_id       <= w_gnt_id;
        r_rr_ptr         <= (32'(w_gnt_id) == NUM_REQ - 1) ? '0 : ID_W'(w_gnt_id + ID_W'(1));
        r_bmu_ap         <= w_sel_ap;
        r_bmu_a          <= w_sel_a;
        r_bmu_b          <= w_sel_b;
        r_bmu_csr_ren    <= w_sel_csr_ren;
        r_bmu_csr_rddata <= w_sel_csr_rddata;
      end
    end
  end

  // Tag pipeline: the last stage lines up with the BMU result.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int unsigned k = 0; k < BMU_LAT; k++) begin
        r_tag_v[k]  <= 1'b0;
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_v[0]  <= r_bmu_valid && !flush;
      r_tag_id[0] <= r_issue_id;
      for (int unsigned k = 1; k < BMU_LAT; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1] && !flush;
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  assign w_cap   = r_tag_v[BMU_LAT-1] && !flush;
  assign w_rsp_v = (r_count != '0);
  assign w_pop   = w_rsp_v && rsp_ready && !flush;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (flush) begin
      r_inflight <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_inflight <= r_inflight + CNT_W'(w_hs) - CNT_W'(w_cap);
      r_count    <= r_count + CNT_W'(w_cap) - CNT_W'(w_pop);
      if (w_cap) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  // Storage needs no reset: the head is only exposed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_mem_id[r_wr_ptr]   <= r_tag_id[BMU_LAT-1];
      r_mem_data[r_wr_ptr] <= bmu_result_ff;
      r_mem_err[r_wr_ptr]  <= bmu_error;
    end
  end

  assign req_ready         = w_ready;
  assign bmu_valid_in      = r_bmu_valid;
  assign bmu_ap            = r_bmu_ap;
  assign bmu_a_in          = r_bmu_a;
  assign bmu_b_in          = r_bmu_b;
  assign bmu_csr_ren_in    = r_bmu_csr_ren;
  assign bmu_csr_rddata_in = r_bmu_csr_rddata;
  assign rsp_valid         = w_rsp_v;
  assign rsp_id            = w_rsp_v ? r_mem_id[r_rd_ptr]   : '0;
  assign rsp_data          = w_rsp_v ? r_mem_data[r_rd_ptr] : '0;
  assign rsp_error         = w_rsp_v ? r_mem_err[r_rd_ptr]  : 1'b0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_l)
    !(w_cap && !w_pop && (r_count == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_bmu_req_arbiter.sv
// Directed bench for bmu_req_arbiter with a 1-cycle BMU stand-in (result = a + b,
// error = a[31]) and an in-order response scoreboard.
module tb_bmu_req_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned AP_W    = 32;

  logic                    clk = 1'b0;
  logic                    rst_l = 1'b0;
  logic                    flush = 1'b0;
  logic [NUM_REQ-1:0]      req_valid = '0;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*AP_W-1:0] req_ap = '0;
  logic [NUM_REQ*32-1:0]   req_a = '0;
  logic [NUM_REQ*32-1:0]   req_b = '0;
  logic [NUM_REQ-1:0]      req_csr_ren = '0;
  logic [NUM_REQ*32-1:0]   req_csr_rddata = '0;
  logic                    bmu_valid_in;
  logic [AP_W-1:0]         bmu_ap;
  logic [31:0]             bmu_a_in;
  logic [31:0]             bmu_b_in;
  logic                    bmu_csr_ren_in;
  logic [31:0]             bmu_csr_rddata_in;
  logic [31:0]             bmu_result_ff = '0;
  logic                    bmu_error = 1'b0;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b1;
  logic [0:0]              rsp_id;
  logic [31:0]             rsp_data;
  logic                    rsp_error;

  bmu_req_arbiter #(.NUM_REQ(NUM_REQ), .AP_W(AP_W), .BMU_LAT(1), .RSP_DEPTH(4)) dut (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_ap(req_ap),
    .req_a(req_a), .req_b(req_b), .req_csr_ren(req_csr_ren), .req_csr_rddata(req_csr_rddata),
    .bmu_valid_in(bmu_valid_in), .bmu_ap(bmu_ap), .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in),
    .bmu_csr_ren_in(bmu_csr_ren_in), .bmu_csr_rddata_in(bmu_csr_rddata_in),
    .bmu_result_ff(bmu_result_ff), .bmu_error(bmu_error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  // BMU stand-in with one cycle of latency.
  always @(posedge clk) begin
    if (bmu_valid_in) begin
      bmu_result_ff <= bmu_a_in + bmu_b_in;
      bmu_error     <= bmu_a_in[31];
    end
  end

  typedef struct {
    logic [31:0] id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [1:0]  v;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [1:0]  rdy;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       tbl[10];
  logic [1:0] bp[8];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1);
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Response monitor: every accepted response must match the head of the scoreboard.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_l && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_extra: got id %0d data 0x%08h, want no response (t=%0t)",
                 rsp_id, rsp_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), e.id);
        check("rsp_data", rsp_data, e.data);
        check("rsp_error", 32'(rsp_error), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    int k;
    tbl[0] = '{2'b01, 32'h0000_00F0, 32'h4,         32'h0,         32'h0,    2'b01};
    tbl[1] = '{2'b11, 32'h10,        32'h1,         32'h8000_0020, 32'h3,    2'b10};
    tbl[2] = '{2'b11, 32'h100,       32'h5,         32'h7,         32'h7,    2'b01};
    tbl[3] = '{2'b11, 32'h1,         32'h1,         32'h1234_0000, 32'h5678, 2'b10};
    tbl[4] = '{2'b10, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h2,    2'b10};
    tbl[5] = '{2'b00, 32'h0,         32'h0,         32'h0,         32'h0,    2'b00};
    tbl[6] = '{2'b11, 32'hAAAA_0000, 32'h5555,      32'h9,         32'h9,    2'b01};
    tbl[7] = '{2'b01, 32'h3,         32'h4,         32'h0,         32'h0,    2'b01};
    tbl[8] = '{2'b10, 32'h0,         32'h0,         32'h40,        32'h2,    2'b10};
    tbl[9] = '{2'b00, 32'h0,         32'h0,         32'h0,         32'h0,    2'b00};
    bp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};

    // Reset state, with both requesters asking.
    drive(2'b11, 32'h1, 32'h2, 32'h3, 32'h4);
    #3;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_bmu_valid", 32'(bmu_valid_in), 32'd0);
    check("rst_bmu_a", bmu_a_in, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    @(negedge clk);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rst_l = 1'b1;

    // Table: arbitration pattern with streaming responses.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
      #1;
      check($sformatf("tbl_ready_%0d", i), 32'(req_ready), 32'(tbl[i].rdy));
      if (tbl[i].rdy[0])
        exp_q.push_back('{32'd0, tbl[i].a0 + tbl[i].b0, tbl[i].a0[31]});
      else if (tbl[i].rdy[1])
        exp_q.push_back('{32'd1, tbl[i].a1 + tbl[i].b1, tbl[i].a1[31]});
    end
    @(negedge clk);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    drain("tbl_drain");

    // Single op: latency and field routing.
    @(negedge clk);
    req_ap         = {32'h0, 32'hA5A5_0001};
    req_csr_ren    = 2'b01;
    req_csr_rddata = {32'h0, 32'h0000_C5C5};
    drive(2'b01, 32'h0000_00F0, 32'h4, 32'h0, 32'h0);
    #1;
    check("single_ready", 32'(req_ready), 32'd1);
    exp_q.push_back('{32'd0, 32'h0000_00F4, 1'b0});
    @(negedge clk);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check("single_bmu_valid", 32'(bmu_valid_in), 32'd1);
    check("single_bmu_a", bmu_a_in, 32'h0000_00F0);
    check("single_bmu_b", bmu_b_in, 32'h4);
    check("single_bmu_ap", bmu_ap, 32'hA5A5_0001);
    check("single_bmu_csr_ren", 32'(bmu_csr_ren_in), 32'd1);
    check("single_bmu_csr_data", bmu_csr_rddata_in, 32'h0000_C5C5);
    @(negedge clk);
    #1;
    check("single_bmu_idle", 32'(bmu_valid_in), 32'd0);
    check("single_bmu_a_hold", bmu_a_in, 32'h0000_00F0);
    check("single_rsp_early", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_rsp_data", rsp_data, 32'h0000_00F4);
    drain("single_drain");
    req_csr_ren = 2'b00;

    // Backpressure: four credits, then one more after a single pop.
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_q.push_back('{32'd1, 32'h202, 1'b0});
    exp_q.push_back('{32'd0, 32'h101, 1'b0});
    exp_q.push_back('{32'd1, 32'h202, 1'b0});
    exp_q.push_back('{32'd0, 32'h101, 1'b0});
    exp_q.push_back('{32'd1, 32'h202, 1'b0});
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      drive(2'b11, 32'h100, 32'h1, 32'h200, 32'h2);
      #1;
      check($sformatf("bp_ready_%0d", i), 32'(req_ready), 32'(bp[i]));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_pop_cycle_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_regrant", 32'(req_ready), 32'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp_full_%0d", i), 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    drain("bp_drain");

    // Flush: one buffered, two in flight, then a fresh op.
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      drive(2'b01, 32'h11 + 32'(i), 32'h1, 32'h0, 32'h0);
      #1;
      check($sformatf("fl_ready_%0d", i), 32'(req_ready), 32'd1);
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_buffered", 32'(rsp_valid), 32'd1);
    check("fl_ready_forced", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    rsp_ready = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check("fl_rsp_dropped", 32'(rsp_valid), 32'd0);
    check("fl_bmu_idle", 32'(bmu_valid_in), 32'd0);
    @(negedge clk);
    drive(2'b01, 32'h321, 32'h10, 32'h0, 32'h0);
    #1;
    check("fl_new_ready", 32'(req_ready), 32'd1);
    check("fl_no_rsp_0", 32'(rsp_valid), 32'd0);
    exp_q.push_back('{32'd0, 32'h331, 1'b0});
    @(negedge clk);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check("fl_no_rsp_1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    check("fl_no_rsp_2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    check("fl_new_rsp", 32'(rsp_valid), 32'd1);
    check("fl_new_data", rsp_data, 32'h331);
    drain("fl_drain");

    // Async reset mid-stream, between clock edges.
    @(negedge clk);
    drive(2'b01, 32'h5, 32'h6, 32'h7, 32'h8);
    #1;
    check("ar_pre_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    drive(2'b11, 32'h5, 32'h6, 32'h7, 32'h8);
    #2;
    rst_l = 1'b0;
    exp_q.delete();
    #1;
    check("ar_req_ready", 32'(req_ready), 32'd0);
    check("ar_bmu_valid", 32'(bmu_valid_in), 32'd0);
    check("ar_bmu_a", bmu_a_in, 32'd0);
    check("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_l = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (req_ready == '0 && k < 5);
    check("ar_first_grant", 32'(req_ready), 32'd1);
    exp_q.push_back('{32'd0, 32'hB, 1'b0});
    @(negedge clk);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    drain("ar_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bmu_req_arbiter.md
Name: bmu_req_arbiter

Overview:
- Shares one Bit Manipulation Unit (BMU) datapath between NUM_REQ requesters using a round-robin arbiter.
- Issues at most one operation per cycle onto the BMU input bus and tags each operation with the requester ID.
- Collects each BMU result after the fixed BMU latency and returns it through a credit-protected response FIFO.
- Sits between the decode/issue requesters and the BMU instance.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- AP_W, 32: width of the flattened ALU packet (ap) bus.
- BMU_LAT, 1: cycles from bmu_valid_in sampled high to bmu_result_ff/bmu_error valid (1..4).
- RSP_DEPTH, 4: response FIFO depth; must be >= BMU_LAT+1.

Ports:
- clk  in  1  clock.
- rst_l  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of in-flight and buffered ops.
- req_valid  in  NUM_REQ  per-requester op valid.
- req_ready  out  NUM_REQ  per-requester grant; handshake completes when valid&&ready.
- req_ap  in  NUM_REQ*AP_W  per-requester ALU packet.
- req_a  in  NUM_REQ*32  operand a (signed).
- req_b  in  NUM_REQ*32  operand b.
- req_csr_ren  in  NUM_REQ  CSR read enable.
- req_csr_rddata  in  NUM_REQ*32  CSR read data.
- bmu_valid_in  out  1  to BMU valid_in.
- bmu_ap  out  AP_W  to BMU ap.
- bmu_a_in  out  32  to BMU a_in.
- bmu_b_in  out  32  to BMU b_in.
- bmu_csr_ren_in  out  1  to BMU csr_ren_in.
- bmu_csr_rddata_in  out  32  to BMU csr_rddata_in.
- bmu_result_ff  in  32  from BMU.
- bmu_error  in  1  from BMU.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  clog2(NUM_REQ)  requester ID of response.
- rsp_data  out  32  result.
- rsp_error  out  1  BMU error flag for that op.

Behaviour:
- Reset (rst_l low, asynchronous): the following outputs are 0:
  - req_ready, bmu_valid_in, bmu_ap/a/b/csr outputs
  - rsp_valid, rsp_id, rsp_data, rsp_error
- Reset also clears the tag pipeline, the FIFO and the credit counter, and sets the RR pointer to 0.
- Credits:
  - credit = RSP_DEPTH - (fifo_count + inflight).
  - Issue is allowed only when credit > 0 and flush = 0.
  - A simultaneous FIFO pop in the same cycle does not add credit until the next cycle (conservative).
- Arbitration:
  - Combinational round-robin starting at rr_ptr.
  - The granted index g gets req_ready[g]=1; all other req_ready bits are 0.
  - req_ready is 0 for every requester when issue is not allowed.
  - After a handshake, rr_ptr = (g+1) mod NUM_REQ. rr_ptr is unchanged if nothing is granted.
- Issue (registered, 1 cycle):
  - On a handshake, the next cycle drives bmu_valid_in=1 with the granted requester's ap/a/b/csr fields, and pushes the tag {valid=1, id=g} into a BMU_LAT-deep shift pipeline.
  - Without a handshake, bmu_valid_in=0 and the data outputs hold their previous values.
- Capture: when a valid tag exits the pipeline (BMU_LAT cycles after bmu_valid_in was high), {id, bmu_result_ff, bmu_error} is pushed into the FIFO. Credits guarantee the FIFO never overflows; an overflow is a design error and is flagged by an assertion.
- Response: rsp_* reflect the FIFO head (show-ahead). Pop on rsp_valid&&rsp_ready. Push and pop in the same cycle are both legal, including when the FIFO is full or empty-with-bypass-off (no combinational bypass: an empty FIFO gives rsp_valid=0 that cycle).
- Ordering: responses leave in issue order; there is no reordering between requesters.
- Flush:
  - In the flush cycle: clear all tag valid bits, empty the FIFO, drop rsp_valid next cycle, force req_ready=0, and drive bmu_valid_in=0 next cycle.
  - rr_ptr is preserved.
  - Results that the BMU returns for killed tags are discarded.
- Reset mid-operation: everything is discarded; there is no response for ops that were in flight.
- Widths: the id is zero-extended to rsp_id width. Unused NUM_REQ non-power-of-two ID codes never appear.

Test Plan:
- Single op: req0 valid, a=0x0000_00F0, b=0x4, BMU_LAT=1 -> req_ready[0] high in cycle 0, bmu_valid_in high in cycle 1, rsp_valid in cycle 3 with rsp_id=0 and rsp_data = BMU result.
- Contention: req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence is 0,1,0,1; sustained throughput is 1 op/cycle.
- Backpressure: rsp_ready=0, RSP_DEPTH=4, both requesters valid -> exactly 4 ops issued, then all req_ready=0. Raising rsp_ready for 1 cycle -> exactly one more grant, which appears no earlier than 1 cycle later.
- Error propagation: BMU returns bmu_error=1 on the 2nd of 3 ops -> the 2nd response has rsp_error=1 and the others have rsp_error=0.
- Flush: 2 ops in flight and 1 buffered, flush pulse -> rsp_valid=0 the next cycle; no responses appear for those 3 ops; a new op issued 2 cycles later returns normally.
- Async reset: assert rst_l=0 mid-stream, between clock edges -> all outputs go to 0 immediately; after release, the first grant goes to req0.
